// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit, its datapath and bench.
// Holds opcode/funct codes, the 4-bit FSM state encodings, the ALU operation
// codes and the datapath mux select codes.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13,
    S_JR        = 4'd14
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_RA  = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  // States that stall on mem_ready and are subject to the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_mc_wait_timer.sv
// Memory-wait timeout counter.
//   clk, reset : clock, async active-high reset
//   clear      : zero the counter (outside wait states or when memory responds)
//   waiting    : in a wait state with mem_ready low this cycle
//   expired    : this wait cycle is the MEM_TIMEOUT-th consecutive one
module mips_mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (waiting) cnt <= cnt + W'(1);
  end

  // cnt holds the number of earlier stalled cycles; the count reaches the
  // limit on this cycle only if memory is still not ready, so a late
  // mem_ready on the limit cycle suppresses the trap.
  assign expired = (MEM_TIMEOUT > 0) && waiting && (cnt == W'(LIM));

endmodule

// File: rtl/mips_multicycle_control.sv
// Sequencing control FSM for the multi-cycle MIPS datapath.
//   clk, reset        : clock, async active-high reset
//   opcode, funct     : fields of the externally held IR
//   zero              : ALU zero flag (branch decision)
//   mem_ready         : memory completes the current access
//   pc_write..pc_source : datapath controls, decoded from the state
//   state_out         : current state for debug
//   trap, illegal_op, mem_err : trap status (sticky until reset)
//   instr_count       : retired-instruction counter
module mips_multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic [2:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state_out,
  output logic                 trap,
  output logic                 illegal_op,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t state, next;
  logic   in_wait, waiting, expired, retire;

  assign in_wait = is_wait_state(state);
  assign waiting = in_wait & ~mem_ready;

  // Clearing outside wait states guarantees a zero count on entry to each.
  mips_mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (~in_wait | mem_ready),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = S_FETCH;
      S_FETCH:  if (mem_ready) next = S_DECODE;
                else if (expired) next = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:         next = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:     next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   next = S_BRANCH;
          OP_ADDI, OP_ORI,
          OP_LUI:           next = S_I_EXEC;
          OP_J, OP_JAL:     next = S_JUMP;
          default:          next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next = S_MEM_WB;
                   else if (expired) next = S_TRAP;
      S_MEM_WRITE: if (mem_ready) next = S_FETCH;
                   else if (expired) next = S_TRAP;
      S_R_EXEC:    next = S_R_WB;
      S_I_EXEC:    next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JR: next = S_FETCH;
      S_TRAP:      next = S_TRAP;
      default:     next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    ext_zero   = 1'b0;
    alu_op     = ALU_ADD;
    pc_source  = PCS_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_BR;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_write  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_zero  = (opcode == OP_ORI) || (opcode == OP_LUI);
        alu_op    = (opcode == OP_ORI) ? ALU_OR :
                    (opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        ext_zero  = (opcode == OP_ORI) || (opcode == OP_LUI);
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        pc_source = PCS_REG;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state;
  assign trap      = (state == S_TRAP);

  // Leaving IDLE is not a retirement; a FETCH self-loop is a stall, not an entry.
  assign retire = (next == S_FETCH) && (state != S_IDLE) && (state != S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op  <= 1'b0;
      mem_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == S_DECODE && next == S_TRAP) illegal_op <= 1'b1;
      if (expired) mem_err <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

endmodule
